shared_queueing_domain: RTL and testbench

//  Multi-queue buffer: NUM_QUEUES logical FIFOs share one DATA_SIZE x DEPTH simple-dual-port RAM.
//  A free-list of RAM addresses feeds per-queue address FIFOs. Sits between dispatcher (enqueue) and scheduler/serializer (dequeue).

---
 rtl/shared_qd_pkg.sv | 14 +
 rtl/shared_queueing_domain_addr_fifo.sv | 34 +++
 rtl/shared_queueing_domain.sv | 66 ++++++
 tb/tb_shared_queueing_domain.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shared_qd_pkg.sv
// shared_qd_pkg: configuration and shared types for shared_queueing_domain
package shared_qd_pkg;
  localparam int NUM_QUEUES = 4;
  localparam int DATA_SIZE = 678;
  localparam int DEPTH = 16;
  localparam int QUEUE_CAP = 16;
  localparam int REGISTER_SIZE = 32;
  localparam int QW = $clog2(NUM_QUEUES);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(QUEUE_CAP) + 1;
  typedef logic [QW-1:0] qid_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [OW-1:0] occ_t;
endpackage

// File: rtl/shared_queueing_domain_addr_fifo.sv
// addr_fifo: pointer FIFO with live count; FILL preloads entries 0..N-1 at reset (free-list use)
module addr_fifo #(
  parameter int N = 16,
  parameter int W = 4,
  parameter bit FILL = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         push_data,
  output logic [W-1:0]         head,
  output logic [$clog2(N):0]   count
);
  localparam int PW = $clog2(N);
  logic [W-1:0] mem [N];
  logic [PW-1:0] rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clock) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= FILL ? (PW+1)'(N) : '0;
      if (FILL) for (int i = 0; i < N; i++) mem[i] <= W'(i);
    end else begin
      if (push) begin
        mem[wr] <= push_data;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/shared_queueing_domain.sv
// shared_queueing_domain: NUM_QUEUES FIFOs sharing one RAM through a free-list of addresses.
// SHARED_QD_WATERMARK_EN adds per-queue high_water tracking with wm_clear.
module shared_queueing_domain
  import shared_qd_pkg::*;
(
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enq_valid,
  output logic                                    enq_ready,
  input  qid_t                                    enq_id,
  input  logic [DATA_SIZE-1:0]                    enq_packet,
  input  logic                                    deq_req,
  input  qid_t                                    deq_id,
  output logic                                    deq_accept,
  output logic                                    deq_valid,
  output logic [DATA_SIZE-1:0]                    deq_packet,
  input  logic [NUM_QUEUES-1:0][REGISTER_SIZE-1:0] thresholds,
  output occ_t [NUM_QUEUES-1:0]                   occupancy,
  output logic [NUM_QUEUES-1:0]                   empty,
  output logic [NUM_QUEUES-1:0]                   full,
  output logic [NUM_QUEUES-1:0]                   throttle,
  output logic                                    pool_empty
`ifdef SHARED_QD_WATERMARK_EN
  ,
  input  logic                                    wm_clear,
  output occ_t [NUM_QUEUES-1:0]                   high_water
`endif
);
  logic [DATA_SIZE-1:0] ram [DEPTH];
  addr_t free_head;
  addr_t [NUM_QUEUES-1:0] q_head;
  logic [AW:0] free_count;
  logic enq_fire;
  assign pool_empty = free_count == '0;
  assign enq_ready = ~pool_empty & ~full[enq_id];
  assign enq_fire = enq_valid & enq_ready;
  assign deq_accept = deq_req & ~empty[deq_id];
  // A popped address goes straight back to the free-list; enq_ready only sees it next cycle
  addr_fifo #(.N(DEPTH), .W(AW), .FILL(1'b1)) u_free (
    .clock, .reset,
    .push(deq_accept), .pop(enq_fire), .push_data(q_head[deq_id]),
    .head(free_head), .count(free_count)
  );
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
    addr_fifo #(.N(QUEUE_CAP), .W(AW), .FILL(1'b0)) u_fifo (
      .clock, .reset,
      .push(enq_fire && enq_id == qid_t'(q)), .pop(deq_accept && deq_id == qid_t'(q)),
      .push_data(free_head), .head(q_head[q]), .count(occupancy[q])
    );
    assign empty[q] = occupancy[q] == '0;
    assign full[q] = occupancy[q] == occ_t'(QUEUE_CAP);
    assign throttle[q] = thresholds[q] != '0 && REGISTER_SIZE'(occupancy[q]) >= thresholds[q];
  end
  always_ff @(posedge clock) begin
    if (enq_fire) ram[free_head] <= enq_packet;
    if (deq_accept) deq_packet <= ram[q_head[deq_id]];
  end
  always_ff @(posedge clock) deq_valid <= reset ? 1'b0 : deq_accept;
`ifdef SHARED_QD_WATERMARK_EN
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_QUEUES; i++)
      if (reset || wm_clear) high_water[i] <= '0;
      else if (occupancy[i] > high_water[i]) high_water[i] <= occupancy[i];
  end
`endif
endmodule

// File: tb/tb_shared_queueing_domain.sv
// tb_shared_queueing_domain: table-driven vectors plus directed multi-cycle sequences
module tb_shared_queueing_domain;
  import shared_qd_pkg::*;
  logic clock = 1'b0;
  logic reset, enq_valid, enq_ready, deq_req, deq_accept, deq_valid, pool_empty;
  qid_t enq_id, deq_id;
  logic [DATA_SIZE-1:0] enq_packet, deq_packet;
  logic [NUM_QUEUES-1:0][REGISTER_SIZE-1:0] thresholds;
  occ_t [NUM_QUEUES-1:0] occupancy;
  logic [NUM_QUEUES-1:0] empty, full, throttle;
`ifdef SHARED_QD_WATERMARK_EN
  logic wm_clear = 1'b0;
  occ_t [NUM_QUEUES-1:0] high_water;
`endif
  shared_queueing_domain dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_id(enq_id), .enq_packet(enq_packet),
    .deq_req(deq_req), .deq_id(deq_id), .deq_accept(deq_accept),
    .deq_valid(deq_valid), .deq_packet(deq_packet),
    .thresholds(thresholds), .occupancy(occupancy), .empty(empty), .full(full),
    .throttle(throttle), .pool_empty(pool_empty)
`ifdef SHARED_QD_WATERMARK_EN
    , .wm_clear(wm_clear), .high_water(high_water)
`endif
  );
  always #5 clock = ~clock;

  typedef struct {
    logic ev; logic [1:0] eid; logic [7:0] et;
    logic dr; logic [1:0] did;
    logic er; logic da; logic [7:0] dt; logic [19:0] occ;
  } vec_t;
  vec_t tbl[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [679:0] act, input logic [679:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [DATA_SIZE-1:0] mk(input logic [7:0] t);
    logic [679:0] v;
    v = {85{t}};
    return v[DATA_SIZE-1:0];
  endfunction
  task automatic drive(input logic ev, input int eid, input logic [7:0] et, input logic dr, input int did);
    enq_valid = ev; enq_id = qid_t'(eid); enq_packet = mk(et);
    deq_req = dr; deq_id = qid_t'(did);
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic add(input logic ev, input int eid, input logic [7:0] et, input logic dr, input int did,
                     input logic er, input logic da, input logic [7:0] dt,
                     input int o0, input int o1, input int o2, input int o3);
    tbl.push_back('{ev, 2'(eid), et, dr, 2'(did), er, da, dt, {5'(o3), 5'(o2), 5'(o1), 5'(o0)}});
  endtask

  initial begin
    //  ev eid et     dr did er da dt     q0 q1 q2 q3
    add(1, 2, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0);
    add(1, 2, 8'hB2, 0, 0, 1, 0, 8'h00, 0, 0, 2, 0);
    add(1, 2, 8'hC3, 0, 0, 1, 0, 8'h00, 0, 0, 3, 0);
    add(0, 0, 8'h00, 1, 2, 1, 1, 8'hA1, 0, 0, 2, 0);
    add(0, 0, 8'h00, 1, 2, 1, 1, 8'hB2, 0, 0, 1, 0);
    add(0, 0, 8'h00, 1, 2, 1, 1, 8'hC3, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 3, 1, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 8'h10 + 8'(i), 0, 0, 1, 0, 8'h00, 0, i + 1, 0, 0);
    add(1, 1, 8'h15, 1, 1, 1, 1, 8'h10, 0, 5, 0, 0);
    add(1, 0, 8'h20, 1, 1, 1, 1, 8'h11, 1, 4, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1, 1, 8'h20, 0, 4, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 1, 1, 1, 1, 8'h12 + 8'(i), 0, 3 - i, 0, 0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);

    thresholds = '0;
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_empty", empty, 4'hF);
    chk("rst_full", full, 0);
    chk("rst_throttle", throttle, 0);
    chk("rst_pool_empty", pool_empty, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_enq_ready", enq_ready, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ev, tbl[i].eid, tbl[i].et, tbl[i].dr, tbl[i].did);
      #1;
      chk($sformatf("v%0d_enq_ready", i), enq_ready, tbl[i].er);
      chk($sformatf("v%0d_deq_accept", i), deq_accept, tbl[i].da);
      tick;
      chk($sformatf("v%0d_deq_valid", i), deq_valid, tbl[i].da);
      if (tbl[i].da) chk($sformatf("v%0d_deq_packet", i), deq_packet, mk(tbl[i].dt));
      chk($sformatf("v%0d_occupancy", i), occupancy, tbl[i].occ);
    end

    // fill q0 until the whole pool is consumed
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i), 0, 0);
      tick;
    end
    chk("fill_occ0", occupancy[0], 16);
    chk("fill_full", full, 4'b0001);
    chk("fill_pool_empty", pool_empty, 1);
    drive(1, 1, 8'h77, 0, 0);
    #1 chk("fill_enq_ready_q1", enq_ready, 0);
    tick;
    chk("fill_occ1_blocked", occupancy[1], 0);
    // pop of a full queue plus enqueue to it: enqueue gated by pre-cycle state
    drive(1, 0, 8'hEE, 1, 0);
    #1 chk("full_pop_enq_ready", enq_ready, 0);
    chk("full_pop_deq_accept", deq_accept, 1);
    tick;
    chk("full_pop_deq_valid", deq_valid, 1);
    chk("full_pop_packet", deq_packet, mk(8'h00));
    chk("full_pop_occ0", occupancy[0], 15);
    chk("full_pop_pool_empty", pool_empty, 0);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 0, 1, 0);
      tick;
      chk($sformatf("drain_packet%0d", i), deq_packet, mk(8'(i)));
    end
    drive(0, 0, 0, 0, 0);
    tick;
    chk("drain_deq_valid", deq_valid, 0);
    chk("drain_occupancy", occupancy, 0);

    // throttle threshold on q1
    thresholds[1] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'h30 + 8'(i), 0, 0);
      tick;
      chk($sformatf("thr_throttle%0d", i), throttle, (i == 3) ? 4'b0010 : 4'b0000);
    end
    drive(0, 0, 0, 1, 1);
    tick;
    chk("thr_deq_packet", deq_packet, mk(8'h30));
    chk("thr_throttle_drop", throttle, 0);
    thresholds = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 8'h40 + 8'(i), 0, 0);
      tick;
      chk($sformatf("thr_off%0d", i), throttle, 0);
    end
    chk("thr_occ1", occupancy[1], 11);

    // reset overlapping a dequeue discards the in-flight read
    drive(0, 0, 0, 1, 1);
    reset = 1'b1;
    tick;
    chk("rst_deq_valid_inflight", deq_valid, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick;
    chk("rst2_deq_valid", deq_valid, 0);
    chk("rst2_occupancy", occupancy, 0);
    chk("rst2_pool_empty", pool_empty, 0);
    for (int i = 0; i < 16; i++) begin
      drive(1, 3, 8'h50 + 8'(i), 0, 0);
      #1 chk($sformatf("rst2_enq_ready%0d", i), enq_ready, 1);
      tick;
    end
    chk("rst2_pool_full_use", pool_empty, 1);
    chk("rst2_occ3", occupancy[3], 16);
    drive(0, 0, 0, 1, 3);
    tick;
    chk("rst2_first_packet", deq_packet, mk(8'h50));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
